// File: rtl/wgt_load_ctrl_if.sv
// Weight stream interface between the weight SRAM reader (master) and the
// weight-load sequencer (slave). Signed 8-bit weights with valid/ready.
interface wgt_load_ctrl_if;
  logic signed [7:0] s_wgt_data;
  logic              s_wgt_valid;
  logic              s_wgt_ready;

  modport master (
    output s_wgt_data,
    output s_wgt_valid,
    input  s_wgt_ready
  );

  modport slave (
    input  s_wgt_data,
    input  s_wgt_valid,
    output s_wgt_ready
  );
endinterface

// File: rtl/wgt_load_ctrl.sv
// Weight-load sequencer: takes ROWS*COLS signed weights over a valid/ready
// stream and drives the shared weight bus plus a one-hot read strobe so that
// weight k lands in PE k (raster order), then pulses done.
// Optional feature: define WGT_LOAD_PERF_EN to add the 16-bit stall_cnt port
// counting valid-low cycles while loading.
module wgt_load_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    abort,
  wgt_load_ctrl_if.slave          s_wgt,
  output logic signed [7:0]       wgt_bus,
  output logic [ROWS*COLS-1:0]    wgt_read,
  output logic                    busy,
  output logic                    done
`ifdef WGT_LOAD_PERF_EN
  ,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [N-1:0]      read_q;
  logic [N-1:0]      one_hot_base;
  logic signed [7:0] bus_q;
  logic              done_q;
  logic              handshake;
  logic              start_ok;
  logic              abort_ok;
  logic              last_idx;

  assign one_hot_base = {{(N-1){1'b0}}, 1'b1};

  // Abort only matters while a load is active and always beats a handshake;
  // start is accepted only in IDLE and loses to a simultaneous abort.
  assign abort_ok  = abort && (state != IDLE);
  assign start_ok  = start && !abort && (state == IDLE);
  assign handshake = (state == LOAD) && s_wgt.s_wgt_valid && !abort;
  assign last_idx  = (idx == IDX_W'(N - 1));

  // Next-state and index logic.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = LOAD;
          idx_next   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (s_wgt.s_wgt_valid) begin
          if (last_idx) begin
            state_next = DRAIN;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Data path: latch the accepted weight onto the bus and raise PE k's strobe
  // for the following cycle; done fires in the IDLE cycle after a clean DRAIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_q  <= '0;
      read_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (handshake) begin
        bus_q  <= s_wgt.s_wgt_data;
        read_q <= one_hot_base << idx;
      end else begin
        read_q <= '0;
      end
      done_q <= (state == DRAIN) && !abort;
    end
  end

`ifdef WGT_LOAD_PERF_EN
  // Stall counter: cleared by an accepted start, counts valid-low LOAD cycles
  // (not the abort cycle) and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == LOAD) && !s_wgt.s_wgt_valid && !abort &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  // A pending strobe is suppressed in the abort cycle so the PE never latches.
  assign wgt_read          = abort_ok ? '0 : read_q;
  assign wgt_bus           = bus_q;
  assign done              = done_q;
  assign busy              = (state != IDLE);
  assign s_wgt.s_wgt_ready = (state == LOAD);

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Directed self-checking bench for wgt_load_ctrl with a 2x2 array (N=4).
module tb_wgt_load_ctrl;

  logic              clk;
  logic              rstn;
  logic              start;
  logic              abort;
  logic signed [7:0] wgt_bus;
  logic [3:0]        wgt_read;
  logic              busy;
  logic              done;
`ifdef WGT_LOAD_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  int compared;
  int mismatched;
  int data_v[4];

  wgt_load_ctrl_if s_wgt();

  wgt_load_ctrl #(.ROWS(2), .COLS(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .s_wgt    (s_wgt),
    .wgt_bus  (wgt_bus),
    .wgt_read (wgt_read),
    .busy     (busy),
    .done     (done)
`ifdef WGT_LOAD_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and settle before checks.
  task automatic applyStimulus(input logic st, input logic ab, input logic vl, input int dt);
    @(negedge clk);
    start             = st;
    abort             = ab;
    s_wgt.s_wgt_valid = vl;
    s_wgt.s_wgt_data  = 8'(dt);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    data_v     = '{5, -3, 127, -128};
    start             = 1'b0;
    abort             = 1'b0;
    s_wgt.s_wgt_valid = 1'b0;
    s_wgt.s_wgt_data  = '0;
    rstn = 1'b1;
    #2 rstn = 1'b0;

    // Reset state.
    @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", s_wgt.s_wgt_ready, 0);
    checkOutput("rst_bus", wgt_bus, 0);
    checkOutput("rst_read", wgt_read, 0);
    checkOutput("rst_done", done, 0);
`ifdef WGT_LOAD_PERF_EN
    checkOutput("rst_stall", stall_cnt, 0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    // Idle for ten cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 7);
      checkOutput("idle_read", wgt_read, 0);
      checkOutput("idle_busy", busy, 0);
    end

    // Full-rate load.
    $display("[TB] full-rate load");
    applyStimulus(1, 0, 0, 0);
    checkOutput("fr_busy_at_start", busy, 0);
    applyStimulus(0, 0, 1, data_v[0]);
    checkOutput("fr_busy", busy, 1);
    checkOutput("fr_ready", s_wgt.s_wgt_ready, 1);
    checkOutput("fr_read0", wgt_read, 0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(0, 0, 1, data_v[k]);
      checkOutput("fr_read", wgt_read, 1 << (k - 1));
      checkOutput("fr_bus", wgt_bus, data_v[k - 1]);
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("fr_read_last", wgt_read, 8);
    checkOutput("fr_bus_last", wgt_bus, -128);
    checkOutput("fr_done_early", done, 0);
    checkOutput("fr_busy_drain", busy, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fr_done", done, 1);
    checkOutput("fr_busy_end", busy, 0);
    checkOutput("fr_read_end", wgt_read, 0);
    checkOutput("fr_bus_hold", wgt_bus, -128);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fr_done_pulse", done, 0);

    // Gapped valid: two valid-low cycles between weights.
    $display("[TB] gapped load");
    applyStimulus(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 1, data_v[k]);
      checkOutput("gap_read_hs", wgt_read, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("gap_read", wgt_read, 1 << k);
      checkOutput("gap_bus", wgt_bus, data_v[k]);
      checkOutput("gap_done_early", done, 0);
      if (k < 3) begin
        applyStimulus(0, 0, 0, 0);
        checkOutput("gap_read_idle", wgt_read, 0);
        checkOutput("gap_busy", busy, 1);
      end
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("gap_done", done, 1);
    checkOutput("gap_busy_end", busy, 0);
`ifdef WGT_LOAD_PERF_EN
    checkOutput("gap_stall", stall_cnt, 6);
`endif

    // Abort in the strobe cycle of the second weight.
    $display("[TB] abort");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 5);
    applyStimulus(0, 0, 1, -3);
    checkOutput("ab_read_first", wgt_read, 1);
    applyStimulus(0, 1, 1, 127);
    checkOutput("ab_read_masked", wgt_read, 0);
    checkOutput("ab_busy", busy, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ab_busy_after", busy, 0);
    checkOutput("ab_read_after", wgt_read, 0);
    checkOutput("ab_bus_kept", wgt_bus, -3);
    checkOutput("ab_done_after", done, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ab_done_later", done, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 9);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ab_reload_read", wgt_read, 1);
    checkOutput("ab_reload_bus", wgt_bus, 9);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("ab2_busy", busy, 0);

    // Start while loading is ignored; start in the done cycle is accepted.
    $display("[TB] ignored start and back-to-back");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, data_v[0]);
    applyStimulus(1, 0, 1, data_v[1]);
    checkOutput("ign_read0", wgt_read, 1);
    applyStimulus(1, 0, 1, data_v[2]);
    checkOutput("ign_read1", wgt_read, 2);
    applyStimulus(0, 0, 1, data_v[3]);
    checkOutput("ign_read2", wgt_read, 4);
    applyStimulus(1, 0, 0, 0);
    checkOutput("ign_read3", wgt_read, 8);
    applyStimulus(1, 0, 0, 0);
    checkOutput("b2b_done", done, 1);
    applyStimulus(0, 0, 1, 11);
    checkOutput("b2b_busy", busy, 1);
    checkOutput("b2b_ready", s_wgt.s_wgt_ready, 1);
    checkOutput("b2b_done_pulse", done, 0);
    applyStimulus(0, 0, 1, 22);
    checkOutput("b2b_read0", wgt_read, 1);
    checkOutput("b2b_bus0", wgt_bus, 11);
    applyStimulus(0, 0, 1, 33);
    checkOutput("b2b_read1", wgt_read, 2);

    // Asynchronous reset mid-load.
    $display("[TB] reset mid-load");
    rstn = 1'b0;
    #1;
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_read", wgt_read, 0);
    checkOutput("mr_bus", wgt_bus, 0);
    checkOutput("mr_ready", s_wgt.s_wgt_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 1, 44);
      checkOutput("mr_read_after", wgt_read, 0);
      checkOutput("mr_done_after", done, 0);
      checkOutput("mr_busy_after", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
